// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy controller defuzzification path.
package fuzzy_pkg;

  localparam int LONGBITS_DEFAULT = 10;
  localparam int DEF_NUM_W = $clog2(LONGBITS_DEFAULT * (LONGBITS_DEFAULT - 1) / 2 + 1);
  localparam int DEF_CNT_W = $clog2(LONGBITS_DEFAULT + 1);
  localparam int DEF_IDX_W = $clog2(LONGBITS_DEFAULT);

  typedef logic [LONGBITS_DEFAULT-1:0] LongBitSum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } defuzz_state_e;

endpackage

// File: rtl/fuzzy_serial_div.sv
// Restoring divider, MSB first, one quotient bit per cycle (DVD_W cycles).
// done marks the final iteration; quotient holds the result from the next cycle on.
module fuzzy_serial_div #(
  parameter int DVD_W = 6,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] quo_r;
  logic [DVS_W:0]   rem_r;
  logic [DVS_W-1:0] dvs_r;
  logic [CW-1:0]    left_r;
  logic [DVS_W:0]   shifted_s;
  logic [DVS_W:0]   diff_s;
  logic             fits_s;

  // A set top remainder bit already guarantees the trial value exceeds the divisor.
  always_comb begin
    shifted_s = {rem_r[DVS_W-1:0], quo_r[DVD_W-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    fits_s    = rem_r[DVS_W] | (shifted_s >= {1'b0, dvs_r});
  end

  assign done     = (left_r == CW'(1));
  assign quotient = quo_r;

  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r  <= '0;
      rem_r  <= '0;
      dvs_r  <= '0;
      left_r <= '0;
    end else if (start) begin
      quo_r  <= dividend;
      rem_r  <= '0;
      dvs_r  <= divisor;
      left_r <= CW'(DVD_W);
    end else if (left_r != '0) begin
      quo_r  <= {quo_r[DVD_W-2:0], fits_s};
      rem_r  <= fits_s ? diff_s : shifted_s;
      left_r <= left_r - CW'(1);
    end else begin
      quo_r  <= quo_r;
      rem_r  <= rem_r;
      left_r <= left_r;
    end
  end

endmodule

// File: rtl/fuzzy_centroid_defuzz.sv
// Centroid defuzzifier: serial bit scan then serial divide, valid/ready on both sides.
// Optional FUZZY_DEFUZZ_ROUND_EN switches truncation to round-half-up division.
module fuzzy_centroid_defuzz
  import fuzzy_pkg::*;
#(
  parameter int LongBits_limit = LONGBITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LongBits_limit-1:0] in_z,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(LongBits_limit)-1:0] out_crisp,
  output logic                      out_empty
);

  localparam int NUM_W = $clog2(LongBits_limit * (LongBits_limit - 1) / 2 + 1);
  localparam int CNT_W = $clog2(LongBits_limit + 1);
  localparam int IDX_W = $clog2(LongBits_limit);

  defuzz_state_e state_r, state_next_s;

  logic [LongBits_limit-1:0] z_r;
  logic [NUM_W-1:0] num_r, num_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] crisp_s;
  logic             accept_s, scan_last_s, div_start_s, div_done_s;
  logic             in_ready_r, out_valid_r, out_empty_r;
  logic [IDX_W-1:0] out_crisp_r;

`ifdef FUZZY_DEFUZZ_ROUND_EN
  localparam int DVD_W = NUM_W + 1;
  logic [DVD_W-1:0] dividend_s;
  assign dividend_s = {1'b0, num_next_s} + DVD_W'(cnt_next_s[CNT_W-1:1]);
`else
  localparam int DVD_W = NUM_W;
  logic [DVD_W-1:0] dividend_s;
  assign dividend_s = num_next_s;
`endif

  logic [DVD_W-1:0] quo_s;

  assign accept_s    = in_valid && in_ready_r;
  assign scan_last_s = (idx_r == IDX_W'(LongBits_limit - 1));
  assign div_start_s = (state_r == SCAN) && scan_last_s && (cnt_next_s != '0);

  // Accumulate index sum and member count for the bit currently scanned.
  always_comb begin
    num_next_s = num_r;
    cnt_next_s = cnt_r;
    if (z_r[idx_r]) begin
      num_next_s = num_r + NUM_W'(idx_r);
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      num_next_s = num_r;
      cnt_next_s = cnt_r;
    end
  end

  fuzzy_serial_div #(
    .DVD_W (DVD_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (dividend_s),
    .divisor  (cnt_next_s),
    .done     (div_done_s),
    .quotient (quo_s)
  );

  // A quotient that cannot be an index would mean corrupted state; clamp it.
  generate
    if (DVD_W > IDX_W) begin : g_sat
      always_comb begin
        if (|quo_s[DVD_W-1:IDX_W]) begin
          crisp_s = IDX_W'(LongBits_limit - 1);
        end else begin
          crisp_s = quo_s[IDX_W-1:0];
        end
      end
    end else begin : g_direct
      assign crisp_s = IDX_W'(quo_s);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = SCAN;
        else          state_next_s = IDLE;
      end
      SCAN: begin
        if (!scan_last_s)          state_next_s = SCAN;
        else if (cnt_next_s == '0) state_next_s = DONE;
        else                       state_next_s = DIV;
      end
      DIV: begin
        if (div_done_s) state_next_s = DONE;
        else            state_next_s = DIV;
      end
      DONE: begin
        if (out_valid_r && out_ready) state_next_s = IDLE;
        else                          state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Scan datapath: the vector is captured once so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_r   <= '0;
      num_r <= '0;
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            z_r   <= in_z;
            num_r <= '0;
            cnt_r <= '0;
            idx_r <= '0;
          end
        end
        SCAN: begin
          num_r <= num_next_s;
          cnt_r <= cnt_next_s;
          idx_r <= scan_last_s ? '0 : idx_r + IDX_W'(1);
        end
        default: begin
          z_r <= z_r;
        end
      endcase
    end
  end

  // Output registers: result is loaded on the first DONE cycle, then held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_crisp_r <= '0;
      out_empty_r <= 1'b0;
    end else begin
      in_ready_r <= (state_next_s == IDLE);
      if (state_r == DONE && !out_valid_r) begin
        out_valid_r <= 1'b1;
        out_empty_r <= (cnt_r == '0);
        out_crisp_r <= (cnt_r == '0) ? '0 : crisp_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_crisp = out_crisp_r;
  assign out_empty = out_empty_r;

endmodule

// File: doc/fuzzy_centroid_defuzz.md
Name: fuzzy_centroid_defuzz

Overview:
Sequential defuzzifier for the fuzzy controller datapath. It takes one aggregated membership vector, where bit i set means universe point i is a member. This is the vector produced by the per-bit min/max combine stage. It returns the crisp centroid index, floor(sum(i*z[i]) / sum(z[i])).
- Serial bit scan followed by a serial restoring divide.
- Valid/ready handshake on both sides.
- Sits between the rule-aggregation stage and the actuator output register.

Parameters:
LongBits_limit, 10, number of universe points (bits of the membership vector); must be >= 2
NUM_W, $clog2(LongBits_limit*(LongBits_limit-1)/2+1) (localparam), numerator width (6 at default)
CNT_W, $clog2(LongBits_limit+1) (localparam), member-count width (4 at default)
IDX_W, $clog2(LongBits_limit) (localparam), crisp output width (4 at default)

Ports:
clk        input   1               clock; all state changes on rising edge
rst_n      input   1               reset, asynchronous, active-low
in_valid   input   1               membership vector valid
in_ready   output  1               block can accept a vector
in_z       input   LongBits_limit  aggregated membership vector (LongBitSum)
out_valid  output  1               crisp result valid
out_ready  input   1               downstream accepts result
out_crisp  output  IDX_W           centroid index
out_empty  output  1               input vector had no members (out_crisp forced 0)

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE; in_ready=1; out_valid=0; out_crisp=0; out_empty=0.
  - Internal vector, accumulators and divider registers cleared.
- FSM states: IDLE, SCAN, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_z; num=0, cnt=0, idx=0; go to SCAN.
- SCAN:
  - One bit per cycle, idx = 0..LongBits_limit-1.
  - If z[idx]: num+=idx, cnt+=1.
  - After idx=LongBits_limit-1 (exactly LongBits_limit cycles):
    - final cnt==0: go to DONE with out_crisp=0, out_empty=1.
    - otherwise go to DIV.
- DIV:
  - Restoring division num/cnt, MSB first, one quotient bit per cycle, exactly NUM_W cycles.
  - Remainder register width CNT_W+1.
  - Quotient truncated to IDX_W bits; it always fits, since quotient <= LongBits_limit-1.
  - Then go to DONE with out_empty=0.
- DONE:
  - out_valid=1; out_crisp and out_empty held stable while out_ready=0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency, acceptance edge to out_valid high:
  - non-empty vector: LongBits_limit+NUM_W+1 cycles (17 at defaults).
  - empty vector: LongBits_limit+1 cycles (11).
- Throughput: one vector per (latency + 1 handshake cycle); no overlap.
- in_ready=0 in SCAN/DIV/DONE; in_valid there is ignored and in_z is not sampled.
- Output side: no combinational path from out_ready to in_ready.
- Reset asserted mid-SCAN/DIV/DONE: immediate return to the reset values; the partial result is discarded and never presented.
- in_z changing after acceptance has no effect on the result.

Optional Feature:
FUZZY_DEFUZZ_ROUND_EN:
- Defined: before DIV, num is replaced by num + (cnt>>1), giving round-half-up.
  - Numerator register widened by 1 bit; DIV takes NUM_W+1 cycles.
  - Latency +1 on non-empty vectors.
- Undefined: truncating division exactly as above.
- out_empty behaviour is identical in both builds.

Decomposition:
- Shared package fuzzy_pkg holds:
  - LongBits_limit default and the LongBitSum typedef.
  - The defuzzifier FSM state enum.
  - The helper constants NUM_W/CNT_W/IDX_W.
- One natural sub-module: fuzzy_serial_div, the restoring divider.
  - Interface: start/done, dividend NUM_W, divisor CNT_W, quotient NUM_W.
  - Reusable by later weighted-average blocks.

Test Plan:
- Single member: in_z=10'b0000010000 -> out_crisp=4, out_empty=0, out_valid 17 cycles after accept.
- All members: in_z=10'h3FF (num=45, cnt=10) -> out_crisp=4; with FUZZY_DEFUZZ_ROUND_EN -> 5, latency 18.
- Empty: in_z=0 -> out_crisp=0, out_empty=1, out_valid 11 cycles after accept; DIV never entered.
- Endpoints and backpressure: in_z=10'b1000000001 -> out_crisp=4 (round build 5).
  - Hold out_ready=0 for 20 cycles: outputs stable, in_ready=0, new in_valid ignored.
  - Release: next vector accepted only after out_valid drops.
- Reset mid-operation: assert rst_n=0 during DIV cycle 3 -> next cycle out_valid=0, in_ready=1.
  - Subsequent in_z=10'b0000000100 -> out_crisp=2.
